// File: rtl/btn_cond_pkg.sv
// Purpose : shared types and helpers for the button_conditioner block.
// Latency : n/a (types, constants and constant functions only).
// Backpr. : n/a.
// Contents: per-channel FSM state enum, released-level function, counter-width helpers.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } btn_state_t;

  // Raw pin value that means "not pressed" for a given polarity.
  function automatic logic released_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  // Bits needed to hold values 0..max_val inclusive (at least 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// Purpose : one button: synchroniser, debounce, hold FSM, press/release/long/repeat strobes.
// Latency : pin edge to btn_level/btn_press = SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges incl. the sampling edge.
// Backpr. : none; all outputs are free-running single-cycle strobes or levels.
// Ports   : clk, rst_n (async active-low), raw (pin), repeat_en;
//           btn_level, btn_press, btn_release, btn_long, btn_repeat, btn_action.
module button_channel
  import btn_cond_pkg::*;
#(
  parameter int ACTIVE_LOW        = 1,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int REPEAT_CYCLES     = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_repeat,
  output logic btn_action
);

  localparam logic REL    = released_level(ACTIVE_LOW != 0);
  localparam int   DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int   HOLD_W = cnt_width(max_int(LONG_PRESS_CYCLES, REPEAT_CYCLES));

  localparam logic [DB_W-1:0]   DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] LP_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] RP_LAST = HOLD_W'(REPEAT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        db_cnt;
  logic                   pressed_s;
  logic                   db_done;
  logic                   press_evt;
  logic                   rel_evt;

  btn_state_t             state_q, state_nxt;
  logic [HOLD_W-1:0]      hold_q, hold_nxt;
  logic                   long_nxt;
  logic                   repeat_nxt;

  // XOR with the released level normalises either polarity to pressed=1.
  assign pressed_s = sync_q[SYNC_STAGES-1] ^ REL;

  // Counter holding DB_MAX means the input has disagreed with the level long enough.
  assign db_done   = (pressed_s != btn_level) && (db_cnt == DB_MAX);
  assign press_evt = db_done && !btn_level;
  assign rel_evt   = db_done &&  btn_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= {SYNC_STAGES{REL}};
      db_cnt      <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], raw};
      btn_press   <= press_evt;
      btn_release <= rel_evt;
      if (pressed_s == btn_level) begin
        db_cnt <= '0;
      end else if (db_done) begin
        db_cnt    <= '0;
        btn_level <= ~btn_level;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      btn_long   <= 1'b0;
      btn_repeat <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      hold_q     <= hold_nxt;
      btn_long   <= long_nxt;
      btn_repeat <= repeat_nxt;
    end
  end

  // Hold counter reads k in the k-th cycle after the press strobe; the long
  // strobe (and first repeat) lands LONG_PRESS_CYCLES after the press strobe.
  // A release in the same cycle pre-empts long/repeat.
  always_comb begin
    state_nxt  = state_q;
    hold_nxt   = hold_q;
    long_nxt   = 1'b0;
    repeat_nxt = 1'b0;
    case (state_q)
      IDLE: begin
        hold_nxt = '0;
        if (press_evt) begin
          state_nxt = HELD;
        end
      end
      HELD: begin
        if (rel_evt) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else if (hold_q == LP_LAST) begin
          state_nxt  = LONG;
          hold_nxt   = '0;
          long_nxt   = 1'b1;
          repeat_nxt = repeat_en;
        end else begin
          hold_nxt = hold_q + 1'b1;
        end
      end
      LONG: begin
        // Period timing runs regardless of repeat_en; enable only gates the strobe.
        if (rel_evt) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else if (hold_q == RP_LAST) begin
          hold_nxt   = '0;
          repeat_nxt = repeat_en;
        end else begin
          hold_nxt = hold_q + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  assign btn_action = btn_press | btn_repeat;

endmodule

// File: rtl/button_conditioner.sv
// Purpose : NUM_BTN independent button conditioners (sync, debounce, press/release/long/repeat).
// Latency : pin edge to btn_level/btn_press = SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges incl. the sampling edge.
// Backpr. : none; outputs are levels and single-cycle strobes.
// Ports   : CLOCK, reset_n (async active-low), ORG_BUTTON[NUM_BTN] raw pins, repeat_en[NUM_BTN];
//           btn_level, btn_press, btn_release, btn_long, btn_repeat, btn_action (all [NUM_BTN]).
module button_conditioner
  import btn_cond_pkg::*;
#(
  parameter int NUM_BTN           = 3,
  parameter int ACTIVE_LOW        = 1,
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int REPEAT_CYCLES     = 10000000
) (
  input  logic               CLOCK,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] ORG_BUTTON,
  input  logic [NUM_BTN-1:0] repeat_en,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic [NUM_BTN-1:0] btn_action
);

  // Elaboration-time legality checks.
  if (NUM_BTN < 1) begin : g_bad_num_btn
    $error("button_conditioner: NUM_BTN must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("button_conditioner: LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("button_conditioner: REPEAT_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW        (ACTIVE_LOW),
      .SYNC_STAGES       (SYNC_STAGES),
      .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
      .REPEAT_CYCLES     (REPEAT_CYCLES)
    ) u_ch (
      .clk         (CLOCK),
      .rst_n       (reset_n),
      .raw         (ORG_BUTTON[i]),
      .repeat_en   (repeat_en[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i]),
      .btn_repeat  (btn_repeat[i]),
      .btn_action  (btn_action[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Purpose : directed checks of button_conditioner with short debounce/long/repeat timings.
// Latency : n/a (testbench).
// Backpr. : n/a.
module tb_button_conditioner;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_REP   = 3;
  localparam int K_ACT   = 4;
  localparam int K_LVL   = 5;

  logic       CLOCK;
  logic       reset_n;
  logic [2:0] ORG_BUTTON;
  logic [2:0] repeat_en;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic [2:0] btn_release;
  logic [2:0] btn_long;
  logic [2:0] btn_repeat;
  logic [2:0] btn_action;

  button_conditioner #(
    .NUM_BTN           (3),
    .ACTIVE_LOW        (1),
    .SYNC_STAGES       (2),
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (20),
    .REPEAT_CYCLES     (6)
  ) dut (
    .CLOCK       (CLOCK),
    .reset_n     (reset_n),
    .ORG_BUTTON  (ORG_BUTTON),
    .repeat_en   (repeat_en),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .btn_repeat  (btn_repeat),
    .btn_action  (btn_action)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int ch;
    int kind;
    int cyc;
  } ev_t;

  ev_t evq[$];
  int  edge_cnt = 0;
  int  n_checks = 0;
  int  n_errors = 0;

  // Log every asserted output bit, tagged with the number of the edge it followed.
  always @(posedge CLOCK) begin
    edge_cnt = edge_cnt + 1;
    #1;
    for (int c = 0; c < 3; c++) begin
      if (btn_press[c])   evq.push_back('{c, K_PRESS, edge_cnt});
      if (btn_release[c]) evq.push_back('{c, K_REL,   edge_cnt});
      if (btn_long[c])    evq.push_back('{c, K_LONG,  edge_cnt});
      if (btn_repeat[c])  evq.push_back('{c, K_REP,   edge_cnt});
      if (btn_action[c])  evq.push_back('{c, K_ACT,   edge_cnt});
      if (btn_level[c])   evq.push_back('{c, K_LVL,   edge_cnt});
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ch/kind of -1 match anything; window is inclusive.
  function automatic int count_ev(input int ch, input int kind, input int lo, input int hi);
    int n = 0;
    foreach (evq[i]) begin
      if ((ch < 0 || evq[i].ch == ch) && (kind < 0 || evq[i].kind == kind) &&
          evq[i].cyc >= lo && evq[i].cyc <= hi) n++;
    end
    return n;
  endfunction

  function automatic int first_ev(input int ch, input int kind, input int lo);
    int best = -1;
    foreach (evq[i]) begin
      if (evq[i].ch == ch && evq[i].kind == kind && evq[i].cyc >= lo &&
          (best < 0 || evq[i].cyc < best)) best = evq[i].cyc;
    end
    return best;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  int e0, r0, t0, e1;

  initial begin
    reset_n    = 1'b0;
    ORG_BUTTON = 3'b111;
    repeat_en  = 3'b000;
    cycles(3);
    check_eq("rst_level",   int'(btn_level),   0);
    check_eq("rst_press",   int'(btn_press),   0);
    check_eq("rst_release", int'(btn_release), 0);
    check_eq("rst_long",    int'(btn_long),    0);
    check_eq("rst_repeat",  int'(btn_repeat),  0);
    check_eq("rst_action",  int'(btn_action),  0);
    reset_n = 1'b1;
    cycles(10);
    check_eq("idle_no_events", count_ev(-1, -1, 0, edge_cnt), 0);

    // 1. clean press and release on ch0
    ORG_BUTTON[0] = 1'b0; e0 = edge_cnt + 1;
    cycles(6);
    check_eq("t1_level_edge5", int'(btn_level[0]), 0);
    cycles(1);
    check_eq("t1_level_edge6", int'(btn_level[0]), 1);
    cycles(8);
    check_eq("t1_press_cyc",  first_ev(0, K_PRESS, e0), e0 + 6);
    check_eq("t1_press_cnt",  count_ev(0, K_PRESS, e0, edge_cnt), 1);
    check_eq("t1_action_cyc", first_ev(0, K_ACT, e0), e0 + 6);
    ORG_BUTTON[0] = 1'b1; r0 = edge_cnt + 1;
    cycles(12);
    check_eq("t1_release_cyc", first_ev(0, K_REL, r0), r0 + 6);
    check_eq("t1_release_cnt", count_ev(0, K_REL, r0, edge_cnt), 1);
    check_eq("t1_level_low",   int'(btn_level[0]), 0);

    // 2. bounce on ch1: 3-cycle pulses never survive debounce
    e0 = edge_cnt + 1;
    for (int i = 0; i < 40; i++) begin
      ORG_BUTTON[1] = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      cycles(1);
    end
    ORG_BUTTON[1] = 1'b1;
    cycles(10);
    check_eq("t2_ch1_quiet", count_ev(1, -1, e0, edge_cnt), 0);
    check_eq("t2_all_quiet", count_ev(-1, -1, e0, edge_cnt), 0);

    // 3. long hold on ch0, repeat disabled
    repeat_en = 3'b000;
    ORG_BUTTON[0] = 1'b0; e0 = edge_cnt + 1; t0 = e0 + 6;
    cycles(40);
    ORG_BUTTON[0] = 1'b1; r0 = edge_cnt + 1;
    cycles(12);
    check_eq("t3_press_cyc",   first_ev(0, K_PRESS, e0), t0);
    check_eq("t3_press_cnt",   count_ev(0, K_PRESS, e0, edge_cnt), 1);
    check_eq("t3_long_cyc",    first_ev(0, K_LONG, e0), t0 + 20);
    check_eq("t3_long_cnt",    count_ev(0, K_LONG, e0, edge_cnt), 1);
    check_eq("t3_repeat_cnt",  count_ev(0, K_REP, e0, edge_cnt), 0);
    check_eq("t3_release_cyc", first_ev(0, K_REL, r0), r0 + 6);

    // 4. auto-repeat on ch2
    repeat_en = 3'b100;
    ORG_BUTTON[2] = 1'b0; e0 = edge_cnt + 1; t0 = e0 + 6;
    cycles(40);
    ORG_BUTTON[2] = 1'b1; r0 = edge_cnt + 1;
    cycles(12);
    check_eq("t4_press_cyc",  first_ev(2, K_PRESS, e0), t0);
    check_eq("t4_long_cyc",   first_ev(2, K_LONG, e0), t0 + 20);
    check_eq("t4_rep1_cyc",   first_ev(2, K_REP, e0), t0 + 20);
    check_eq("t4_rep2_cyc",   first_ev(2, K_REP, t0 + 21), t0 + 26);
    check_eq("t4_rep3_cyc",   first_ev(2, K_REP, t0 + 27), t0 + 32);
    check_eq("t4_rep4_cyc",   first_ev(2, K_REP, t0 + 33), t0 + 38);
    check_eq("t4_rep_cnt",    count_ev(2, K_REP, e0, edge_cnt), 4);
    check_eq("t4_action_cnt", count_ev(2, K_ACT, e0, edge_cnt), 5);
    check_eq("t4_release_cyc", first_ev(2, K_REL, r0), r0 + 6);

    // 4b. repeat_en dropped after the T+26 repeat
    ORG_BUTTON[2] = 1'b0; e0 = edge_cnt + 1; t0 = e0 + 6;
    cycles(34);
    repeat_en = 3'b000;
    cycles(6);
    ORG_BUTTON[2] = 1'b1;
    cycles(12);
    check_eq("t4b_rep_cnt",    count_ev(2, K_REP, e0, edge_cnt), 2);
    check_eq("t4b_rep_late",   first_ev(2, K_REP, t0 + 27), -1);
    check_eq("t4b_action_cnt", count_ev(2, K_ACT, e0, edge_cnt), 3);
    check_eq("t4b_long_cnt",   count_ev(2, K_LONG, e0, edge_cnt), 1);

    // 5. reset while ch0 is in LONG
    ORG_BUTTON[0] = 1'b0; e0 = edge_cnt + 1;
    cycles(30);
    check_eq("t5_long_cyc", first_ev(0, K_LONG, e0), e0 + 26);
    check_eq("t5_level_pre", int'(btn_level[0]), 1);
    reset_n = 1'b0;
    #1;
    check_eq("t5_rst_level", int'(btn_level), 0);
    check_eq("t5_rst_strobes",
             int'(btn_press | btn_release | btn_long | btn_repeat | btn_action), 0);
    cycles(2);
    reset_n = 1'b1; e1 = edge_cnt + 1;
    cycles(10);
    check_eq("t5_press_cyc", first_ev(0, K_PRESS, e1), e1 + 6);
    check_eq("t5_press_cnt", count_ev(0, K_PRESS, e1, edge_cnt), 1);
    ORG_BUTTON[0] = 1'b1;
    cycles(12);

    // 6. ch0 and ch1 pressed together, ch1 released early
    ORG_BUTTON = 3'b100; e0 = edge_cnt + 1;
    cycles(8);
    ORG_BUTTON[1] = 1'b1; r0 = edge_cnt + 1;
    cycles(12);
    check_eq("t6_press0_cyc", first_ev(0, K_PRESS, e0), e0 + 6);
    check_eq("t6_press1_cyc", first_ev(1, K_PRESS, e0), e0 + 6);
    check_eq("t6_rel1_cyc",   first_ev(1, K_REL, r0), r0 + 6);
    check_eq("t6_rel0_cnt",   count_ev(0, K_REL, e0, edge_cnt), 0);
    check_eq("t6_level",      int'(btn_level), 1);
    ORG_BUTTON[0] = 1'b1;
    cycles(12);
    check_eq("t6_level_end",  int'(btn_level), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Parametrised, multi-channel successor to the game debouncer.
- Each of NUM_BTN raw push-button inputs is synchronised, debounced, and converted into:
  - a clean pressed level,
  - single-cycle press and release pulses,
  - a long-press pulse,
  - optional auto-repeat pulses.
- Sits between the board pins and ticTacToeCore / menu logic, so cursor movement can auto-repeat while a button is held.

Parameters:
- NUM_BTN, 3, number of independent button channels.
- ACTIVE_LOW, 1, 1 means a raw input of 0 is "pressed".
- SYNC_STAGES, 2, synchroniser depth per channel (>=2).
- DEBOUNCE_CYCLES, 500000, cycles an input must be stable before the level changes (10 ms at 50 MHz; >=1).
- LONG_PRESS_CYCLES, 50000000, cycles held after press before long-press fires (1 s; >DEBOUNCE_CYCLES).
- REPEAT_CYCLES, 10000000, auto-repeat period after long-press (200 ms; >=2).

Ports:
- CLOCK  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- ORG_BUTTON  input  NUM_BTN  raw asynchronous button pins, polarity per ACTIVE_LOW.
- repeat_en  input  NUM_BTN  per-channel auto-repeat enable, sampled every cycle.
- btn_level  output  NUM_BTN  debounced level, 1 = pressed.
- btn_press  output  NUM_BTN  1-cycle pulse on debounced press.
- btn_release  output  NUM_BTN  1-cycle pulse on debounced release.
- btn_long  output  NUM_BTN  1-cycle pulse, once per hold, at long-press threshold.
- btn_repeat  output  NUM_BTN  1-cycle auto-repeat pulses while held.
- btn_action  output  NUM_BTN  btn_press OR btn_repeat; drop-in "step" strobe for the core.

Behaviour:
- Reset (async assert, sync release at next CLOCK edge):
  - Synchroniser flops load the released value (ACTIVE_LOW ? 1 : 0).
  - All counters are 0, all FSMs are IDLE.
  - All outputs are 0.
- Channels are fully independent; simultaneous events on different channels are each reported in the same cycle.
- Synchroniser: the raw input passes through SYNC_STAGES flops, then is normalised to pressed=1.
- Debounce counter (width clog2(DEBOUNCE_CYCLES+1)):
  - Clears whenever the synchronised value equals btn_level.
  - Otherwise increments.
  - When it reaches DEBOUNCE_CYCLES: btn_level toggles and the counter clears.
  - Any reversion before reaching DEBOUNCE_CYCLES restarts it (glitch rejection).
- Latency from a clean input edge to a btn_level change: SYNC_STAGES + DEBOUNCE_CYCLES rising edges.
- btn_press and btn_release are registered and asserted in the same cycle btn_level changes.
- Per-channel FSM:
  - IDLE: btn_level=0. Goes to HELD on debounced press.
  - HELD: hold counter runs from 0. After LONG_PRESS_CYCLES cycles (counted from the press-pulse cycle), btn_long pulses, then go to LONG. Debounced release returns to IDLE.
  - LONG: if repeat_en=1, btn_repeat pulses in the cycle btn_long fires and every REPEAT_CYCLES thereafter. Debounced release returns to IDLE.
- Hold counter:
  - Width clog2(max(LONG_PRESS_CYCLES, REPEAT_CYCLES)+1).
  - Wraps to 0 on each repeat.
  - Cleared on release.
  - Never overflows.
- repeat_en handling in LONG:
  - Deasserting it suppresses pulses; timing continues.
  - Reasserting it resumes at the next period boundary.
- btn_long fires at most once per press.
- Release and repeat coincident: the release wins and no repeat pulse is issued that cycle.
- A button already held at reset release produces btn_press SYNC_STAGES+DEBOUNCE_CYCLES cycles later; it is treated as a normal press.
- Reset mid-hold: all outputs drop to 0 immediately (asynchronously).

Decomposition:
- Shared package btn_cond_pkg holds:
  - the FSM state enum (IDLE, HELD, LONG),
  - the released-level constant function of ACTIVE_LOW,
  - a clog2-based counter-width helper.
- Sub-module button_channel implements synchroniser, debounce, FSM and pulse generation for one bit.
- The top generate-instantiates NUM_BTN copies.
- The top adds parameter-legality checks (simulation assertions).

Test Plan (NUM_BTN=3, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=6, ACTIVE_LOW=1):
1. Clean press:
   - Stimulus: ORG_BUTTON[0] 1→0 just before edge 0.
   - Response: btn_level[0]=1 and 1-cycle btn_press[0]/btn_action[0] at edge 6.
   - Release the same way: btn_release[0] 6 edges after the release.
2. Bounce:
   - Stimulus: ORG_BUTTON[1] toggles with 3-cycle pulses for 40 cycles, then returns high.
   - Response: no change on any output of channel 1.
3. Long hold, repeat disabled:
   - Stimulus: hold ch0 for 40 cycles, repeat_en=0.
   - Response: one btn_press at T; one btn_long at T+20; btn_repeat stays 0; btn_release on release.
4. Auto-repeat:
   - Stimulus: repeat_en[2]=1, hold ch2 for 40 cycles.
   - Response: btn_press at T; btn_long and btn_repeat at T+20; btn_repeat at T+26, T+32, T+38; btn_action at T, T+20, T+26, T+32, T+38.
   - Variant: clearing repeat_en at T+27 suppresses T+32 and T+38.
5. Reset mid-hold:
   - Stimulus: hold ch0 to state LONG, then pulse reset_n low for 2 cycles while still held.
   - Response: all outputs 0 during reset; btn_press[0] again 6 edges after reset release.
6. Channel independence:
   - Stimulus: press ch0 and ch1 in the same cycle, release ch1 8 cycles later.
   - Response: simultaneous press pulses; ch0 level unaffected by the ch1 release.
